muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide unit. Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple cycles.
- Sits beside the single-cycle ALU in the execute stage. The decode/execute controller steers M-extension ops here instead of the ALU and stalls until a response returns.
- Uses a valid/ready request/response handshake, plus a flush input so the pipeline can kill an in-flight op.

---
 rtl/muldiv_seq_pkg.sv | 42 ++++
 rtl/md_iter_step.sv | 44 ++++
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit.
//   md_op_e matches the RV32M funct3 encoding so the decoder can pass
//   funct3 straight through. The helpers decode operand signedness and
//   the multiply/divide class from an opcode.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] MIN_SIGNED = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES   = 32'hFFFF_FFFF;

  // All four divide-class opcodes share funct3[2] = 1.
  function automatic logic isDivOp(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  // Remainder ops take the dividend's sign rather than the XOR of signs.
  function automatic logic isRemOp(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic signedA(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic signedB(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// md_iter_step
//   One combinational retire step of the iterative multiplier/divider.
//   The 64-bit accumulator is shared between both operations:
//     multiply: {partial product high, multiplier remaining bits}
//     divide:   {remainder, dividend bits shifting out / quotient shifting in}
//   Ports:
//     div_i   1 = restoring trial-subtract step, 0 = shift-add step
//     acc_i   accumulator entering this step
//     opnd_i  multiplicand (multiply) or divisor (divide) magnitude
//     acc_o   accumulator after this step
module md_iter_step
  import muldiv_seq_pkg::*;
(
  input  logic            div_i,
  input  logic [63:0]     acc_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [63:0]     acc_o
);

  logic [32:0] mulSum;
  logic [32:0] shifted;
  logic [31:0] diffRem;
  logic        ge;

  // Multiply: conditionally add the multiplicand into the upper half, then
  // shift the 65-bit {carry, acc} right by one so the next multiplier bit
  // lands at bit 0.
  // Divide: shift the next dividend bit into the remainder, trial-subtract
  // the divisor, keep the difference only when it did not go negative, and
  // shift the resulting quotient bit in at the bottom. The remainder is
  // always below the divisor, so a non-negative difference fits in 32 bits.
  always_comb begin
    mulSum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    shifted = {acc_i[63:32], acc_i[31]};
    ge      = (shifted >= {1'b0, opnd_i});
    diffRem = shifted[31:0] - opnd_i;
    if (div_i) begin
      acc_o = {(ge ? diffRem : shifted[31:0]), acc_i[30:0], ge};
    end else begin
      acc_o = {mulSum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative RV32M multiply/divide unit beside the execute-stage ALU.
//   Operands are converted to magnitudes at accept, BITS_PER_CYCLE bits are
//   retired per BUSY cycle through a chain of md_iter_step instances, and
//   the sign correction plus result selection happens in one final BUSY
//   cycle before DONE. Divide-by-zero and signed overflow bypass the loop.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     flush                 kill any in-flight op; no response is produced
//     req_valid/req_ready   request handshake; req_ready only in IDLE
//     req_op, req_a, req_b  md_op_e opcode (funct3) and rs1/rs2 operands
//     resp_valid/resp_ready response handshake; held stable in DONE
//     resp_data             registered result
//     busy                  unit is not IDLE
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam logic [5:0] ITER_CNT = 6'(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  md_op_e          op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] respData_q, respData_d;

  // Request-side decode
  md_op_e          opIn;
  logic            signA, signB;
  logic [XLEN-1:0] magA, magB;
  logic            divZero, divOvf;
  logic [XLEN-1:0] fastResult;

  // Finalisation of the iterated accumulator
  logic [63:0]     prodFix;
  logic [XLEN-1:0] quotFix, remFix;
  logic [XLEN-1:0] finalResult;

  logic [BITS_PER_CYCLE:0][63:0] stepAcc;

  assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = respData_q;
  assign busy       = (state_q != S_IDLE);

  // The per-cycle datapath is BITS_PER_CYCLE single-bit steps chained
  // combinationally; the chain output is what the accumulator loads.
  assign stepAcc[0] = acc_q;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : gStep
    md_iter_step uStep (
      .div_i  (isDivOp(op_q)),
      .acc_i  (stepAcc[g]),
      .opnd_i (opnd_q),
      .acc_o  (stepAcc[g+1])
    );
  end

  // Request decode: sign extraction, magnitudes and the two divide corner
  // cases that skip iteration entirely.
  always_comb begin
    opIn    = md_op_e'(req_op);
    signA   = signedA(opIn) && req_a[XLEN-1];
    signB   = signedB(opIn) && req_b[XLEN-1];
    magA    = signA ? (~req_a + 32'd1) : req_a;
    magB    = signB ? (~req_b + 32'd1) : req_b;
    divZero = isDivOp(opIn) && (req_b == '0);
    divOvf  = ((opIn == MD_DIV) || (opIn == MD_REM)) &&
              (req_a == MIN_SIGNED) && (req_b == ALL_ONES);
    if (divZero) begin
      fastResult = isRemOp(opIn) ? req_a : ALL_ONES;
    end else begin
      fastResult = isRemOp(opIn) ? 32'd0 : MIN_SIGNED;
    end
  end

  // Sign correction and result selection from the fully iterated
  // accumulator. neg_q already encodes the right sign for each op class.
  always_comb begin
    prodFix = neg_q ? (~acc_q + 64'd1) : acc_q;
    quotFix = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    remFix  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    unique case (op_q)
      MD_MUL:                      finalResult = prodFix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: finalResult = prodFix[63:32];
      MD_DIV, MD_DIVU:             finalResult = quotFix;
      MD_REM, MD_REMU:             finalResult = remFix;
      default:                     finalResult = prodFix[31:0];
    endcase
  end

  // Next-state logic. Flush overrides everything; the datapath registers
  // are left as they are because nothing reads them outside BUSY/DONE.
  // BUSY runs ITER retire cycles (counter ITER..1) and then one more cycle
  // with the counter at zero to register the corrected result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_d      = neg_q;
    respData_d = respData_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d   = opIn;
            neg_d  = isRemOp(opIn) ? signA : (signA ^ signB);
            // Multiplier (mul) or dividend (div) goes in the low half;
            // the other operand stays fixed in opnd.
            acc_d  = {32'd0, (isDivOp(opIn) ? magA : magB)};
            opnd_d = isDivOp(opIn) ? magB : magA;
            if (divZero || divOvf) begin
              respData_d = fastResult;
              cnt_d      = '0;
              state_d    = S_DONE;
            end else begin
              cnt_d   = ITER_CNT;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != 6'd0) begin
            acc_d = stepAcc[BITS_PER_CYCLE];
            cnt_d = cnt_q - 6'd1;
          end else begin
            respData_d = finalResult;
            state_d    = S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset clears everything, including the
  // visible result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= MD_MUL;
      neg_q      <= 1'b0;
      respData_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      respData_q <= respData_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
//   Directed self-checking bench for muldiv_seq with BITS_PER_CYCLE=1.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // Drive one request, scramble the operand inputs right after accept,
  // measure edges from accept to resp_valid (-1 on timeout), capture the
  // result and complete the response handshake. Entered 1 unit after an edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] data,
                               output int lat);
    int guard;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_F00D;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) lat = -1;
    data = resp_data;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++;
    if (resp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 00000000", resp_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  opT  [5];
    logic [31:0] aT   [5];
    logic [31:0] bT   [5];
    logic [31:0] expT [5];
    logic [31:0] data;
    int          lat;
    opT  = '{MD_MUL, MD_MULHU, MD_MULH, MD_MULHSU, MD_MUL};
    aT   = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    bT   = '{32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    expT = '{32'd42, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(opT[i], aT[i], bT[i], data, lat);
      checks++;
      if (data !== expT[i]) begin errors++; $display("[TB] FAIL mul_data[%0d]: got %h expected %h", i, data, expT[i]); end
      checks++;
      if (lat != 33) begin errors++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  opT  [6];
    logic [31:0] aT   [6];
    logic [31:0] bT   [6];
    logic [31:0] expT [6];
    logic [31:0] data;
    int          lat;
    opT  = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_DIV, MD_REM};
    aT   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    bT   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    expT = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(opT[i], aT[i], bT[i], data, lat);
      checks++;
      if (data !== expT[i]) begin errors++; $display("[TB] FAIL div_data[%0d]: got %h expected %h", i, data, expT[i]); end
      checks++;
      if (lat != 33) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
    end
  endtask

  // Fast-path results are visible right after the accept edge, so the
  // measured edge count from accept is zero.
  task automatic test_fast_path();
    logic [2:0]  opT  [6];
    logic [31:0] aT   [6];
    logic [31:0] bT   [6];
    logic [31:0] expT [6];
    logic [31:0] data;
    int          lat;
    opT  = '{MD_DIVU, MD_REMU, MD_DIV, MD_REM, MD_DIV, MD_REM};
    aT   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234, 32'hFFFF_1234};
    bT   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    expT = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_1234};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(opT[i], aT[i], bT[i], data, lat);
      checks++;
      if (data !== expT[i]) begin errors++; $display("[TB] FAIL fast_data[%0d]: got %h expected %h", i, data, expT[i]); end
      checks++;
      if (lat != 0) begin errors++; $display("[TB] FAIL fast_latency[%0d]: got %0d edges expected 0", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] data;
    int          lat;
    int          guard;
    req_op = MD_MUL; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_resp_timeout: got resp_valid %b expected 1", resp_valid); end
    // Offer a competing request while the response is stalled.
    req_op = MD_DIVU; req_a = 32'd9; req_b = 32'd3; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd12) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid %b data %h expected valid 1 data 0000000c", i, resp_valid, resp_data);
      end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got busy %b valid %b ready %b expected 0 0 1", busy, resp_valid, req_ready);
    end
    applyStimulus(MD_DIVU, 32'd9, 32'd3, data, lat);
    checks++;
    if (data !== 32'd3 || lat != 33) begin
      errors++;
      $display("[TB] FAIL bp_next_op: got data %h lat %0d expected 00000003 lat 33", data, lat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] data;
    int          lat;
    logic        seen;
    req_op = MD_DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    req_op = MD_MUL; req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle: got busy %b valid %b expected 0 0", busy, resp_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_resp: got resp_valid seen %b expected 0", seen); end
    applyStimulus(MD_DIVU, 32'd9, 32'd3, data, lat);
    checks++;
    if (data !== 32'd3 || lat != 33) begin
      errors++;
      $display("[TB] FAIL flush_next_op: got data %h lat %0d expected 00000003 lat 33", data, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    int          lat;
    logic        seen;
    req_op = MD_MUL; req_a = 32'd5; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got valid %b data %h busy %b ready %b expected 0 00000000 0 0",
               resp_valid, resp_data, busy, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_resp: got resp_valid seen %b expected 0", seen); end
    applyStimulus(MD_MUL, 32'd5, 32'd5, data, lat);
    checks++;
    if (data !== 32'd25 || lat != 33) begin
      errors++;
      $display("[TB] FAIL rst_mid_next_op: got data %h lat %0d expected 00000019 lat 33", data, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  opT  [4];
    logic [31:0] aT   [4];
    logic [31:0] bT   [4];
    logic [31:0] expT [4];
    logic [31:0] data;
    int          lat;
    opT  = '{MD_REMU, MD_MULHU, MD_DIVU, MD_MULHSU};
    aT   = '{32'd0, 32'h0001_0000, 32'hFFFF_FFFF, 32'd2};
    bT   = '{32'd0, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF};
    expT = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(opT[i], aT[i], bT[i], data, lat);
      checks++;
      if (data !== expT[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, data, expT[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
